i2c_bit_ctrl: RTL

I2C bit-level controller directly downstream of the I2C clock generator. It consumes the generator's quarter-phase `sclk`/`dclk` waveforms and executes one bus primitive per command: START, STOP, WRITE bit or READ bit. It drives the open-drain SCL/SDA enables and reports per-bit results to the byte-level controller above it.

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_bit_ctrl_if.sv | 29 ++
 rtl/i2c_edge_sync.sv | 37 +++
 rtl/i2c_bit_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bit-level controller.
//   i2c_cmd_t      : 3-bit command code carried on the command handshake
//   I2C_CMD_*      : command encodings (codes 5..7 behave as NOP)
//   bit_state_e    : bit-sequencer FSM states
//   cmd_needs_bus  : true for commands that are only legal while the bus is owned
package i2c_pkg;

  typedef logic [2:0] i2c_cmd_t;

  localparam i2c_cmd_t I2C_CMD_NOP   = 3'd0;
  localparam i2c_cmd_t I2C_CMD_START = 3'd1;
  localparam i2c_cmd_t I2C_CMD_STOP  = 3'd2;
  localparam i2c_cmd_t I2C_CMD_WRITE = 3'd3;
  localparam i2c_cmd_t I2C_CMD_READ  = 3'd4;

  // Each primitive walks one full quarter-phase cycle of the generator.
  typedef enum logic [2:0] {
    StIdle,
    StWaitDr,
    StWaitSr,
    StWaitDf,
    StWaitSf
  } bit_state_e;

  function automatic logic cmd_needs_bus(input i2c_cmd_t c);
    return (c == I2C_CMD_STOP) || (c == I2C_CMD_WRITE) || (c == I2C_CMD_READ);
  endfunction

endpackage

// File: rtl/i2c_bit_ctrl_if.sv
// Command/response channel between the byte-level controller (master) and
// the bit-level controller (slave).
//   cmd, cmd_valid, din          : command request, din sampled with the command
//   cmd_ready                    : command accepted when valid & ready
//   rsp_valid                    : one-cycle completion pulse
//   dout, rsp_err, arb_lost      : per-bit results, valid with rsp_valid
interface i2c_bit_ctrl_if;
  import i2c_pkg::*;

  i2c_cmd_t cmd;
  logic     cmd_valid;
  logic     cmd_ready;
  logic     din;
  logic     rsp_valid;
  logic     dout;
  logic     rsp_err;
  logic     arb_lost;

  modport master (
    output cmd, cmd_valid, din,
    input  cmd_ready, rsp_valid, dout, rsp_err, arb_lost
  );

  modport slave (
    input  cmd, cmd_valid, din,
    output cmd_ready, rsp_valid, dout, rsp_err, arb_lost
  );

endinterface

// File: rtl/i2c_edge_sync.sv
// Synchronizer plus registered edge strobes for one generator phase clock.
//   clk, rst_n : system clock, asynchronous active-low reset
//   sig        : asynchronous phase clock from the generator
//   level      : synchronized level, aligned with the strobes
//   rise, fall : one-cycle strobes, SYNC_STAGES+1 cycles after the input edge
module i2c_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Flops reset high so a released line is the assumed idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise   <= sync_q[SYNC_STAGES-1] & ~prev_q;
      fall   <= ~sync_q[SYNC_STAGES-1] & prev_q;
    end
  end

  assign level = prev_q;

endmodule

// File: rtl/i2c_bit_ctrl.sv
// I2C bit-level controller: runs one START/STOP/WRITE/READ primitive per
// command, paced by the quarter-phase sclk/dclk waveforms of the clock generator.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   sclk, dclk     : generator phase clocks
//   clk_en         : generator enable
//   scl_i, sda_i   : pad inputs
//   scl_oe, sda_oe : open-drain enables, 1 pulls the line low
//   bus            : command/response channel (slave side)
// Build option: define I2C_BIT_ARB_EN to enable arbitration-loss detection.
module i2c_bit_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           sclk,
  input  logic           dclk,
  output logic           clk_en,
  input  logic           scl_i,
  input  logic           sda_i,
  output logic           scl_oe,
  output logic           sda_oe,
  i2c_bit_ctrl_if.slave  bus
);

`ifdef I2C_BIT_ARB_EN
  localparam bit ArbEn = 1'b1;
`else
  localparam bit ArbEn = 1'b0;
`endif

  logic s_level, s_rise, s_fall;
  logic d_level, d_rise, d_fall;

  i2c_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (sclk),
    .level (s_level),
    .rise  (s_rise),
    .fall  (s_fall)
  );

  i2c_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_dclk_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .sig   (dclk),
    .level (d_level),
    .rise  (d_rise),
    .fall  (d_fall)
  );

  // SCL pad readback and the dclk level are not needed by this block.
  logic unused_sigs;
  assign unused_sigs = scl_i ^ d_level;

  bit_state_e state_q;
  i2c_cmd_t   cmd_q;
  logic       din_q, owned_q, rsp_valid_q, rsp_err_q, arb_lost_q, dout_q;
  logic       accept, lost;

  assign accept = bus.cmd_valid & bus.cmd_ready;

  // Only meaningful at d_fall, when SDA should be released by us.
  assign lost = ArbEn && ((cmd_q == I2C_CMD_START) || ((cmd_q == I2C_CMD_WRITE) && din_q))
                && !sda_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_q       <= I2C_CMD_NOP;
      din_q       <= 1'b0;
      owned_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      arb_lost_q  <= 1'b0;
      dout_q      <= 1'b0;
      scl_oe      <= 1'b0;
      sda_oe      <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      scl_oe      <= owned_q & ((state_q == StIdle) | ~s_level);
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cmd_q      <= bus.cmd;
            din_q      <= bus.din;
            rsp_err_q  <= 1'b0;
            arb_lost_q <= 1'b0;
            if ((bus.cmd == I2C_CMD_START) || (owned_q && cmd_needs_bus(bus.cmd))) begin
              state_q <= StWaitDr;
            end else begin
              // NOP or illegal: answer at once, bus untouched.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= cmd_needs_bus(bus.cmd);
            end
          end
        end
        StWaitDr: begin
          if (d_rise) begin
            state_q <= StWaitSr;
            case (cmd_q)
              I2C_CMD_START, I2C_CMD_READ: sda_oe <= 1'b0;
              I2C_CMD_STOP:                sda_oe <= 1'b1;
              I2C_CMD_WRITE:               sda_oe <= ~din_q;
              default: ;
            endcase
          end
        end
        StWaitSr: begin
          if (s_rise) state_q <= StWaitDf;
        end
        StWaitDf: begin
          if (d_fall) begin
            state_q <= StWaitSf;
            if (lost) begin
              arb_lost_q <= 1'b1;
              owned_q    <= 1'b0;
              sda_oe     <= 1'b0;
              scl_oe     <= 1'b0;
            end else begin
              case (cmd_q)
                I2C_CMD_START: sda_oe <= 1'b1;
                I2C_CMD_STOP:  sda_oe <= 1'b0;
                I2C_CMD_READ:  dout_q <= sda_i;
                default: ;
              endcase
            end
          end
        end
        StWaitSf: begin
          if (s_fall) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b1;
            // Override the lagging default so SCL has no glitch at ownership change.
            if (!arb_lost_q) begin
              case (cmd_q)
                I2C_CMD_START: begin
                  owned_q <= 1'b1;
                  scl_oe  <= 1'b1;
                end
                I2C_CMD_STOP: begin
                  owned_q <= 1'b0;
                  scl_oe  <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == StIdle) & ~rsp_valid_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.arb_lost  = arb_lost_q;
  assign bus.dout      = dout_q;
  assign clk_en        = owned_q | (state_q != StIdle);

endmodule
